// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle RV32M multiply/divide unit for the EX stage.
// Multiplication is shift-add and division is restoring, one bit per cycle, on a shared
// 2*XLEN working register. The unit stalls the pipeline while an op is in flight, then
// holds a registered result and pulses done for one cycle.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    EX-stage instruction is an M-extension op
//   funct3   op select: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   op_a     rs1 value (forwarded)
//   op_b     rs2 value (forwarded)
//   flush    kill in-flight op
//   stall    freeze PC, IF/ID and ID/EX this cycle
//   done     result valid this cycle (single-cycle pulse)
//   result   rd value, held until the next accepted op completes
module mdu_sequencer #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int unsigned CntW = $clog2(XLEN);

   logic [1:0]          state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     opd_q, opd_d;     // multiplicand or divisor magnitude
   logic [2:0]          f3_q, f3_d;
   logic                neg_q, neg_d;     // negate final value (remainder: dividend sign)
   logic [XLEN-1:0]     result_q, result_d;

   logic                accept;
   logic                is_div, a_signed, b_signed, sa, sb;
   logic [XLEN-1:0]     mag_a, mag_b, fast_res;
   logic                div_zero, ovf, fast;
   logic [XLEN:0]       hi_add, rem_sh, diff;
   logic [2*XLEN-1:0]   mul_step, div_step, step, prod;
   logic [XLEN-1:0]     mul_res, div_res, quo, rem, fin;

   assign accept = start & ~flush & ((state_q == IDLE) | (state_q == DONE));
   assign stall  = reset_n & (accept | ((state_q == CALC) & ~flush));
   assign done   = (state_q == DONE) & ~flush;
   assign result = result_q;

   // Operand preparation for the accept cycle
   always_comb begin
      is_div   = funct3[2];
      a_signed = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) |
                 (funct3 == 3'b110);
      b_signed = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
      sa       = a_signed & op_a[XLEN-1];
      sb       = b_signed & op_b[XLEN-1];
      mag_a    = sa ? -op_a : op_a;
      mag_b    = sb ? -op_b : op_b;
      div_zero = (op_b == '0);
      ovf      = ((funct3 == 3'b100) | (funct3 == 3'b110)) &
                 (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b);
      fast     = is_div & (div_zero | ovf);
      if (div_zero) fast_res = funct3[1] ? op_a : '1;
      else          fast_res = funct3[1] ? '0 : op_a;
   end

   // One iteration of the shift-add multiplier or restoring divider
   always_comb begin
      hi_add   = acc_q[0] ? ({1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opd_q})
                          : {1'b0, acc_q[2*XLEN-1:XLEN]};
      mul_step = {hi_add, acc_q[XLEN-1:1]};
      rem_sh   = acc_q[2*XLEN-1:XLEN-1];
      diff     = rem_sh - {1'b0, opd_q};
      div_step = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      step     = f3_q[2] ? div_step : mul_step;

      prod     = neg_q ? -step : step;
      mul_res  = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      quo      = step[XLEN-1:0];
      rem      = step[2*XLEN-1:XLEN];
      if (f3_q[1]) div_res = neg_q ? -rem : rem;
      else         div_res = neg_q ? -quo : quo;
      fin      = f3_q[2] ? div_res : mul_res;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opd_d    = opd_q;
      f3_d     = f3_q;
      neg_d    = neg_q;
      result_d = result_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               f3_d  = funct3;
               neg_d = (is_div & funct3[1]) ? sa : (sa ^ sb);
               cnt_d = '0;
               if (fast) begin
                  result_d = fast_res;
                  state_d  = DONE;
               end else begin
                  acc_d   = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                  opd_d   = is_div ? mag_b : mag_a;
                  state_d = CALC;
               end
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            acc_d = step;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(XLEN-1)) begin
               result_d = fin;
               state_d  = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Flush kills everything, including a simultaneous start
      if (flush) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opd_q    <= '0;
         f3_q     <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opd_q    <= opd_d;
         f3_q     <= f3_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed cases plus randomized ops checked
// against an arithmetic reference model.
module tb_mdu_sequencer;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        flush;
   logic        stall;
   logic        done;
   logic [31:0] result;

   int unsigned n_checks;
   int unsigned n_fail;
   logic [31:0] last_res;

   mdu_sequencer #(.XLEN(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .funct3  (funct3),
      .op_a    (op_a),
      .op_b    (op_b),
      .flush   (flush),
      .stall   (stall),
      .done    (done),
      .result  (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return f[2] && (b == 0 || ((f == 3'd4 || f == 3'd6) &&
                                 a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] p;
      int          ia, ib;
      bit          ovf;
      ia  = a;
      ib  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
         3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b);
      start  = s;
      funct3 = f;
      op_a   = a;
      op_b   = b;
   endtask

   // Issue one op in cycle 0 and follow it to its done pulse and back to idle
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b);
      logic [31:0] exp;
      int unsigned want, n;
      bit          got;
      exp  = ref_res(f, a, b);
      want = is_fast(f, a, b) ? 1 : 33;
      drive(1'b1, f, a, b);
      @(negedge clk);
      check_eq({tag, "_stall0"}, 32'(stall), 32'd1);
      tick();
      start = 1'b0;
      n     = 1;
      got   = 0;
      while (!got && n <= 40) begin
         @(negedge clk);
         if (done) got = 1;
         else begin
            check_eq({tag, "_busy"}, 32'(stall), 32'd1);
            tick();
            n++;
         end
      end
      check_eq({tag, "_lat"}, n, want);
      check_eq({tag, "_res"}, result, exp);
      check_eq({tag, "_dstall"}, 32'(stall), 32'd0);
      tick();
      @(negedge clk);
      check_eq({tag, "_idle"}, {30'b0, stall, done}, 32'd0);
      tick();
      last_res = exp;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'($urandom_range(0, 20));
         2:       return 32'h8000_0000;
         3:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n, pulses;
      logic [2:0]  rf;
      logic [31:0] ra, rb;
      n_checks = 0;
      n_fail   = 0;
      last_res = 32'h0;
      flush    = 1'b0;
      reset_n  = 1'b0;
      drive(1'b1, 3'd0, 32'd3, 32'd4);
      #1;
      check_eq("rst_stall", 32'(stall), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_result", result, 32'd0);
      start = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD);
      check_eq("mul_7_m3_val", last_res, 32'hFFFF_FFEB);

      // Flush in cycle 10 of a MUL
      drive(1'b1, 3'd0, 32'd5, 32'd6);
      tick();
      start = 1'b0;
      for (int c = 1; c < 10; c++) tick();
      flush = 1'b1;
      @(negedge clk);
      check_eq("flush_stall", 32'(stall), 32'd0);
      check_eq("flush_done", 32'(done), 32'd0);
      tick();
      flush  = 1'b0;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) pulses++;
         tick();
      end
      check_eq("flush_nodone", pulses, 32'd0);
      check_eq("flush_result", result, last_res);

      // Reset in cycle 15 of a DIVU
      drive(1'b1, 3'd5, 32'd100, 32'd7);
      tick();
      start = 1'b0;
      for (int c = 1; c < 15; c++) tick();
      start   = 1'b1;
      reset_n = 1'b0;
      #1;
      check_eq("midrst_result", result, 32'd0);
      check_eq("midrst_done", 32'(done), 32'd0);
      check_eq("midrst_stall", 32'(stall), 32'd0);
      start = 1'b0;
      tick();
      reset_n = 1'b1;
      pulses  = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) pulses++;
         tick();
      end
      check_eq("midrst_nodone", pulses, 32'd0);

      run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000);
      check_eq("mulh_val", last_res, 32'h4000_0000);
      run_op("mulhu", 3'd3, 32'h8000_0000, 32'h8000_0000);
      check_eq("mulhu_val", last_res, 32'h4000_0000);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check_eq("mulhsu_val", last_res, 32'hFFFF_FFFF);
      run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
      check_eq("div_m7_2_val", last_res, 32'hFFFF_FFFD);
      run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
      check_eq("rem_m7_2_val", last_res, 32'hFFFF_FFFF);
      run_op("divu_100_7", 3'd5, 32'd100, 32'd7);
      check_eq("divu_100_7_val", last_res, 32'd14);
      run_op("remu_100_7", 3'd7, 32'd100, 32'd7);
      check_eq("remu_100_7_val", last_res, 32'd2);
      run_op("divu_by0", 3'd5, 32'd5, 32'd0);
      check_eq("divu_by0_val", last_res, 32'hFFFF_FFFF);
      run_op("rem_by0", 3'd6, 32'd5, 32'd0);
      check_eq("rem_by0_val", last_res, 32'd5);
      run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      check_eq("div_ovf_val", last_res, 32'h8000_0000);
      run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      check_eq("rem_ovf_val", last_res, 32'd0);

      // Back-to-back: start held through CALC, next op accepted in the DONE cycle
      drive(1'b1, 3'd4, 32'd20, 32'd4);
      @(negedge clk);
      check_eq("b2b_stall0", 32'(stall), 32'd1);
      tick();
      for (int c = 1; c <= 32; c++) begin
         @(negedge clk);
         check_eq("b2b_busy", {30'b0, done, stall}, 32'd1);
         tick();
      end
      drive(1'b1, 3'd5, 32'd100, 32'd7);
      @(negedge clk);
      check_eq("b2b_done1", 32'(done), 32'd1);
      check_eq("b2b_res1", result, 32'd5);
      check_eq("b2b_accept", 32'(stall), 32'd1);
      tick();
      start = 1'b0;
      n     = 34;
      while (n <= 80) begin
         @(negedge clk);
         if (done) break;
         tick();
         n++;
      end
      check_eq("b2b_lat2", n, 32'd66);
      check_eq("b2b_res2", result, 32'd14);
      tick();

      // Randomized ops against the reference model
      for (int i = 0; i < 30; i++) begin
         rf = 3'($urandom_range(0, 7));
         ra = pick();
         rb = pick();
         run_op("rand", rf, ra, rb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
